// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, EEPROM read
// command fields and shift-length constants.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    READ,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } boot_state_e;

  localparam logic [7:0]  SPI_READ_OP     = 8'h03;
  localparam logic [15:0] BOOT_START_ADDR = 16'h0000;

  localparam int          BIT_CNT_W = 5;
  localparam logic [4:0]  CMD_BITS  = 5'd24;
  localparam logic [4:0]  WORD_BITS = 5'd16;

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 shifter: divides clk into SCK half-periods of CLK_DIV cycles,
// shifts a command out MSB first and collects 16 bits in. While disabled it
// parks SCK low, rewinds the bit counter and preloads the transmit word.
module spi_shifter
  import boot_pkg::*;
#(
  parameter int CLK_DIV = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [BIT_CNT_W-1:0] i_numBits,
  input  logic [23:0]          i_txData,
  input  logic                 i_miso,
  output logic                 o_sck,
  output logic                 o_mosi,
  output logic [15:0]          o_rxData,
  output logic                 o_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     r_divCnt;
  logic                 r_sck;
  logic [BIT_CNT_W-1:0] r_bitCnt;
  logic [23:0]          r_txShift;
  logic [15:0]          r_rxShift;
  logic                 w_halfEnd;
  logic                 w_lastBit;

  assign w_halfEnd = (r_divCnt == DIV_LAST);
  assign w_lastBit = (r_bitCnt == (i_numBits - 5'd1));
  assign o_done    = i_en && r_sck && w_halfEnd && w_lastBit;
  assign o_sck     = r_sck;
  assign o_mosi    = r_txShift[23];
  assign o_rxData  = r_rxShift;

  // Half-period divider: sample MISO as SCK rises, advance MOSI as SCK falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt  <= '0;
      r_sck     <= 1'b0;
      r_bitCnt  <= '0;
      r_txShift <= '0;
      r_rxShift <= '0;
    end else if (!i_en) begin
      r_divCnt  <= '0;
      r_sck     <= 1'b0;
      r_bitCnt  <= '0;
      r_txShift <= i_txData;
    end else if (w_halfEnd) begin
      r_divCnt <= '0;
      r_sck    <= ~r_sck;
      if (!r_sck) begin
        r_rxShift <= {r_rxShift[14:0], i_miso};
      end else begin
        r_txShift <= {r_txShift[22:0], 1'b0};
        r_bitCnt  <= w_lastBit ? '0 : r_bitCnt + 5'd1;
      end
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: after reset, reads NUM_WORDS big-endian 16-bit words from the
// SPI EEPROM (one continuous READ from address 0) and writes them to SRAM,
// then raises isBooted. Once booted, the SPI pins can be relayed to JTAG.
// Optional feature macro: BOOT_CHECKSUM_EN (an extra trailing word is read
// and compared with the 16-bit wrap-around sum of the image).
module boot_loader
  import boot_pkg::*;
#(
  parameter int NUM_WORDS = 32768,
  parameter int CLK_DIV   = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        jtagTCK,
  input  logic        jtagTDI,
  input  logic        enSPIRelay,
  output logic        relayTdo,
  output logic        spiCsn,
  output logic        spiSck,
  output logic        spiMosi,
  input  logic        spiMiso,
  output logic [15:0] sramAddr,
  inout  wire  [15:0] sramData,
  output logic        sramWr,
  output logic        sramEn,
  output logic        isBooted,
  output logic        bootErr
);

  localparam logic [16:0] WORD_COUNT = 17'(NUM_WORDS);

  boot_state_e          r_state;
  boot_state_e          w_nextState;
  logic [16:0]          r_index;
  logic [16:0]          w_indexNext;
  logic [15:0]          r_sramAddr;
  logic                 w_shEn;
  logic [BIT_CNT_W-1:0] w_numBits;
  logic                 w_sck;
  logic                 w_mosi;
  logic                 w_done;
  logic [15:0]          w_rxData;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]          r_sum;
  logic                 r_ckGot;
`endif

  assign w_indexNext = r_index + 17'd1;
  assign w_numBits   = (r_state == CMD) ? CMD_BITS : WORD_BITS;
`ifdef BOOT_CHECKSUM_EN
  assign w_shEn = (r_state == CMD) || (r_state == READ) || ((r_state == CHECK) && !r_ckGot);
`else
  assign w_shEn = (r_state == CMD) || (r_state == READ);
`endif

  assign sramAddr = r_sramAddr;
  assign sramData = (r_state == WRITE) ? w_rxData : 16'bz;

  spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_shEn),
    .i_numBits(w_numBits),
    .i_txData ({SPI_READ_OP, BOOT_START_ADDR}),
    .i_miso   (spiMiso),
    .o_sck    (w_sck),
    .o_mosi   (w_mosi),
    .o_rxData (w_rxData),
    .o_done   (w_done)
  );

  // State register; reset restarts the whole boot from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Word index, held SRAM address and (optionally) the running image sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index    <= '0;
      r_sramAddr <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_sum      <= '0;
      r_ckGot    <= 1'b0;
`endif
    end else begin
      if ((r_state == READ) && w_done) begin
        r_sramAddr <= r_index[15:0];
      end
      if (r_state == WRITE) begin
        r_index <= w_indexNext;
      end
`ifdef BOOT_CHECKSUM_EN
      if (r_state == WRITE) begin
        r_sum <= r_sum + w_rxData;
      end
      if ((r_state == CHECK) && w_done) begin
        r_ckGot <= 1'b1;
      end
`endif
    end
  end

  // Next-state and pin muxing; relay paths are purely combinational in DONE.
  always_comb begin
    w_nextState = r_state;
    spiCsn      = 1'b1;
    spiSck      = 1'b0;
    spiMosi     = 1'b0;
    relayTdo    = 1'b0;
    sramWr      = 1'b0;
    sramEn      = 1'b0;
    isBooted    = 1'b0;
    bootErr     = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextState = CMD;
      end
      CMD: begin
        spiCsn  = 1'b0;
        spiSck  = w_sck;
        spiMosi = w_mosi;
        if (w_done) w_nextState = READ;
      end
      READ: begin
        spiCsn = 1'b0;
        spiSck = w_sck;
        if (w_done) w_nextState = WRITE;
      end
      WRITE: begin
        spiCsn = 1'b0;
        sramWr = 1'b1;
        sramEn = 1'b1;
        if (w_indexNext < WORD_COUNT) begin
          w_nextState = READ;
        end else begin
`ifdef BOOT_CHECKSUM_EN
          w_nextState = CHECK;
`else
          w_nextState = DONE;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        spiCsn = 1'b0;
        spiSck = w_sck;
        if (r_ckGot) w_nextState = (w_rxData == r_sum) ? DONE : ERROR;
      end
      ERROR: begin
        bootErr = 1'b1;
      end
`endif
      DONE: begin
        isBooted = 1'b1;
        if (enSPIRelay) begin
          spiCsn   = 1'b0;
          spiSck   = jtagTCK;
          spiMosi  = jtagTDI;
          relayTdo = spiMiso;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random images served by an EEPROM
// model, SRAM writes checked by a scoreboard monitor, boot latency and SPI
// clock pattern checked against cycle arithmetic, plus reset and relay cases.
// Honours BOOT_CHECKSUM_EN when the design is built with it.
module tb_boot_loader;

  localparam int NW       = 5;
  localparam int CD       = 2;
  localparam int WORD_CYC = 32 * CD + 1;
`ifdef BOOT_CHECKSUM_EN
  localparam int BOOT_CYC = 1 + 48 * CD + (NW + 1) * WORD_CYC;
`else
  localparam int BOOT_CYC = 1 + 48 * CD + NW * WORD_CYC;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jtagTCK = 1'b0;
  logic        jtagTDI = 1'b0;
  logic        enSPIRelay = 1'b0;
  logic        relayTdo;
  logic        spiCsn;
  logic        spiSck;
  logic        spiMosi;
  logic        spiMiso;
  logic [15:0] sramAddr;
  wire  [15:0] sramData;
  logic        sramWr;
  logic        sramEn;
  logic        isBooted;
  logic        bootErr;

  int          checks = 0;
  int          failures = 0;
  wr_t         expQ[$];

  logic [15:0] img[NW];
  logic [15:0] ckWord = 16'h0;
  int          eeBit = 0;
  logic [23:0] cmdSeen = 24'h0;
  logic        eeMiso = 1'b0;
  logic        modelOn = 1'b1;
  logic        useOverride = 1'b0;
  logic        tbMiso = 1'b0;

  assign spiMiso = useOverride ? tbMiso : eeMiso;

  boot_loader #(
    .NUM_WORDS(NW),
    .CLK_DIV  (CD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .jtagTCK   (jtagTCK),
    .jtagTDI   (jtagTDI),
    .enSPIRelay(enSPIRelay),
    .relayTdo  (relayTdo),
    .spiCsn    (spiCsn),
    .spiSck    (spiSck),
    .spiMosi   (spiMosi),
    .spiMiso   (spiMiso),
    .sramAddr  (sramAddr),
    .sramData  (sramData),
    .sramWr    (sramWr),
    .sramEn    (sramEn),
    .isBooted  (isBooted),
    .bootErr   (bootErr)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream bit k after the command: image words then checksum, MSB first.
  function automatic logic streamBit(input int k);
    int w;
    int b;
    w = k / 16;
    b = 15 - (k % 16);
    if (w < NW) return img[w][b];
    if (w == NW) return ckWord[b];
    return 1'b0;
  endfunction

  // Expected SCK level after c clock edges from reset release, during boot.
  function automatic logic expSck(input int c);
    int t;
    if (c < 1) return 1'b0;
    t = c - 1;
    if (t < 48 * CD) return (t % (2 * CD)) >= CD;
    t = (t - 48 * CD) % WORD_CYC;
    if (t < 32 * CD) return (t % (2 * CD)) >= CD;
    return 1'b0;
  endfunction

  // EEPROM model: deselect rewinds the transaction.
  always @(posedge spiCsn) begin
    eeBit   = 0;
    cmdSeen = 24'h0;
    eeMiso  = 1'b0;
  end

  // EEPROM model: capture the command on rising SCK and check it once complete.
  always @(posedge spiSck) begin
    if (!spiCsn && modelOn) begin
      if (eeBit < 24) cmdSeen = {cmdSeen[22:0], spiMosi};
      eeBit++;
      if (eeBit == 24) checkOutput("spiCmd", {8'h0, cmdSeen}, 32'h030000);
    end
  end

  // EEPROM model: present the next data bit on falling SCK.
  always @(negedge spiSck) begin
    if (!spiCsn && modelOn && eeBit >= 24) eeMiso = streamBit(eeBit - 24);
  end

  // Scoreboard monitor: every SRAM write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && sramWr) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL extraWrite: got addr %0h data %0h expected no write", sramAddr, sramData);
      end else begin
        e = expQ.pop_front();
        checkOutput("sramAddr", {16'h0, sramAddr}, {16'h0, e.addr});
        checkOutput("sramData", {16'h0, sramData}, {16'h0, e.data});
        checkOutput("sramEn", {31'h0, sramEn}, 32'h1);
      end
    end
  end

  task automatic pushImage();
    wr_t e;
    expQ.delete();
    for (int i = 0; i < NW; i++) begin
      e.addr = 16'(i);
      e.data = img[i];
      expQ.push_back(e);
    end
  endtask

  task automatic checkResetPins(input string tag);
    checkOutput({tag, "_csn"}, {31'h0, spiCsn}, 32'h1);
    checkOutput({tag, "_sck"}, {31'h0, spiSck}, 32'h0);
    checkOutput({tag, "_mosi"}, {31'h0, spiMosi}, 32'h0);
    checkOutput({tag, "_tdo"}, {31'h0, relayTdo}, 32'h0);
    checkOutput({tag, "_wr"}, {30'h0, sramWr, sramEn}, 32'h0);
    checkOutput({tag, "_addr"}, {16'h0, sramAddr}, 32'h0);
    checkOutput({tag, "_flags"}, {30'h0, isBooted, bootErr}, 32'h0);
  endtask

  task automatic applyStimulus(input bit corruptCk, input bit relayHeld, input int resetAt);
    logic [15:0] sum;
    int          cyc;
    bit          finished;
    sum = 16'h0;
    for (int i = 0; i < NW; i++) begin
      img[i] = 16'($urandom);
      sum    = sum + img[i];
    end
    ckWord = corruptCk ? sum + 16'd1 : sum;
    pushImage();
    enSPIRelay = relayHeld;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetPins("reset");
    rst = 1'b0;
    if (resetAt > 0) begin
      repeat (resetAt) @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetPins("midReset");
      pushImage();
      @(negedge clk);
      rst = 1'b0;
    end
    cyc = 0;
    finished = 1'b0;
    while (cyc < BOOT_CYC + 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (isBooted || bootErr) begin
        finished = 1'b1;
        break;
      end
      checkOutput("bootSck", {31'h0, spiSck}, {31'h0, expSck(cyc)});
      checkOutput("bootCsn", {31'h0, spiCsn}, 32'h0);
      checkOutput("bootTdo", {31'h0, relayTdo}, 32'h0);
      if (relayHeld) begin
        jtagTCK = 1'($urandom);
        jtagTDI = 1'($urandom);
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL bootTimeout: got no completion after %0d cycles expected %0d", cyc, BOOT_CYC);
    end else begin
      checkOutput("bootCycles", cyc, BOOT_CYC);
    end
    if (relayHeld) begin
      checkOutput("relayAtDoneCsn", {31'h0, spiCsn}, 32'h0);
      checkOutput("relayAtDoneSck", {31'h0, spiSck}, {31'h0, jtagTCK});
      checkOutput("relayAtDoneMosi", {31'h0, spiMosi}, {31'h0, jtagTDI});
    end
    repeat (4) @(negedge clk);
`ifdef BOOT_CHECKSUM_EN
    if (corruptCk) begin
      checkOutput("errFlags", {30'h0, isBooted, bootErr}, 32'h1);
      checkOutput("errCsn", {31'h0, spiCsn}, 32'h1);
    end else begin
      checkOutput("doneFlags", {30'h0, isBooted, bootErr}, 32'h2);
    end
`else
    checkOutput("doneFlags", {30'h0, isBooted, bootErr}, 32'h2);
`endif
    checkOutput("writesDrained", expQ.size(), 0);
    checkOutput("lastAddrHeld", {16'h0, sramAddr}, NW - 1);
    checkOutput("idleWr", {30'h0, sramWr, sramEn}, 32'h0);
    enSPIRelay = 1'b0;
    jtagTCK    = 1'b0;
    jtagTDI    = 1'b0;
    #1;
  endtask

  task automatic relayTest();
    modelOn     = 1'b0;
    useOverride = 1'b1;
    @(negedge clk);
    checkOutput("preRelayCsn", {31'h0, spiCsn}, 32'h1);
    enSPIRelay = 1'b1;
    for (int i = 0; i < 8; i++) begin
      jtagTCK = 1'(i);
      jtagTDI = 1'($urandom);
      tbMiso  = 1'($urandom);
      #2;
      checkOutput("relaySck", {31'h0, spiSck}, {31'h0, jtagTCK});
      checkOutput("relayMosi", {31'h0, spiMosi}, {31'h0, jtagTDI});
      checkOutput("relayCsn", {31'h0, spiCsn}, 32'h0);
      checkOutput("relayTdo", {31'h0, relayTdo}, {31'h0, tbMiso});
    end
    tbMiso     = 1'b1;
    jtagTCK    = 1'b1;
    enSPIRelay = 1'b0;
    #2;
    checkOutput("relayOffCsn", {31'h0, spiCsn}, 32'h1);
    checkOutput("relayOffTdo", {31'h0, relayTdo}, 32'h0);
    checkOutput("relayOffSck", {31'h0, spiSck}, 32'h0);
    jtagTCK     = 1'b0;
    tbMiso      = 1'b0;
    useOverride = 1'b0;
    modelOn     = 1'b1;
  endtask

  // Test sequence.
  initial begin
    applyStimulus(1'b0, 1'b0, 0);
    relayTest();
    applyStimulus(1'b0, 1'b0, 1 + 48 * CD + 2 * WORD_CYC + 13);
    applyStimulus(1'b0, 1'b1, 0);
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(1'b1, 1'b0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
